div_seq: RTL

//  Sequential unsigned restoring divider: the inverse of the CPU's 16x16 -> 32 multiplier.

---
 rtl/div_pkg.sv | 11 +
 rtl/div_step.sv | 31 +++
 rtl/div_seq.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and sizing for the sequential restoring divider.
package div_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DIV_W = 16;
  localparam int CNT_W = $clog2(DIV_W);
endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// then subtract the divisor if it fits.
module div_step
  import div_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic [W-1:0] r,
  input  logic         qmsb,
  input  logic [W-1:0] d,
  output logic [W-1:0] r_next,
  output logic         qbit
);

  logic [W:0] shifted_s;
  logic [W:0] diff_s;

  // trial subtract at W+1 bits so the shifted-out remainder MSB is never lost
  always_comb begin
    shifted_s = {r, qmsb};
    diff_s    = shifted_s - {1'b0, d};
    if (shifted_s >= {1'b0, d}) begin
      r_next = diff_s[W-1:0];
      qbit   = 1'b1;
    end else begin
      r_next = shifted_s[W-1:0];
      qbit   = 1'b0;
    end
  end

endmodule

// File: rtl/div_seq.sv
// Sequential unsigned restoring divider, 2W/W -> W quotient and W remainder.
// Divide-by-zero and quotient overflow finish in one cycle with saturated quotient.
module div_seq
  import div_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2*W-1:0]   inp1,
  input  logic [W-1:0]     inp2,
  output logic [W-1:0]     quo,
  output logic [W-1:0]     rem,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic             ovf
);

  localparam int CW = $clog2(W);

  div_state_t    state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [W-1:0]  r_r, r_s;
  logic [W-1:0]  q_r, q_s;
  logic [W-1:0]  d_r, d_s;
  logic [W-1:0]  quo_r, quo_s;
  logic [W-1:0]  rem_r, rem_s;
  logic          dz_r, dz_s;
  logic          ovf_r, ovf_s;
  logic          done_r, done_s;
  logic          busy_r;
  logic [W-1:0]  step_r_s;
  logic          step_qbit_s;
  logic [W-1:0]  q_shift_s;

  div_step #(.W(W)) u_step (
    .r      (r_r),
    .qmsb   (q_r[W-1]),
    .d      (d_r),
    .r_next (step_r_s),
    .qbit   (step_qbit_s)
  );

  assign q_shift_s = {q_r[W-2:0], step_qbit_s};

  // next-state and datapath update for the IDLE/RUN/DONE sequence
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    r_s     = r_r;
    q_s     = q_r;
    d_s     = d_r;
    quo_s   = quo_r;
    rem_s   = rem_r;
    dz_s    = dz_r;
    ovf_s   = ovf_r;
    done_s  = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          if (inp2 == {W{1'b0}}) begin
            dz_s    = 1'b1;
            ovf_s   = 1'b0;
            quo_s   = {W{1'b1}};
            rem_s   = inp1[W-1:0];
            done_s  = 1'b1;
            state_s = DONE;
          end else if (inp1[2*W-1:W] >= inp2) begin
            // quotient would not fit in W bits
            dz_s    = 1'b0;
            ovf_s   = 1'b1;
            quo_s   = {W{1'b1}};
            rem_s   = inp1[W-1:0];
            done_s  = 1'b1;
            state_s = DONE;
          end else begin
            r_s     = inp1[2*W-1:W];
            q_s     = inp1[W-1:0];
            d_s     = inp2;
            cnt_s   = {CW{1'b0}};
            dz_s    = 1'b0;
            ovf_s   = 1'b0;
            state_s = RUN;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        r_s   = step_r_s;
        q_s   = q_shift_s;
        cnt_s = cnt_r + CW'(1);
        if (cnt_r == CW'(W - 1)) begin
          quo_s   = q_shift_s;
          rem_s   = step_r_s;
          done_s  = 1'b1;
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // state, datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
      r_r     <= {W{1'b0}};
      q_r     <= {W{1'b0}};
      d_r     <= {W{1'b0}};
      quo_r   <= {W{1'b0}};
      rem_r   <= {W{1'b0}};
      dz_r    <= 1'b0;
      ovf_r   <= 1'b0;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      r_r     <= r_s;
      q_r     <= q_s;
      d_r     <= d_s;
      quo_r   <= quo_s;
      rem_r   <= rem_s;
      dz_r    <= dz_s;
      ovf_r   <= ovf_s;
      done_r  <= done_s;
      busy_r  <= (state_s == RUN);
    end
  end

  assign quo  = quo_r;
  assign rem  = rem_r;
  assign busy = busy_r;
  assign done = done_r;
  assign dz   = dz_r;
  assign ovf  = ovf_r;

endmodule
